// File: rtl/adc_sample_scheduler.sv
// Paces mcp3002 conversions at SAMPLE_RATE, captures each 10-bit result into a FWFT FIFO
// and keeps saturating counts of lost samples and abandoned conversions.
module adc_sample_scheduler #(
   parameter int unsigned CLK_FREQ       = 27_000_000,
   parameter int unsigned SAMPLE_RATE    = 20_000,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             run,
   output logic                             adc_enable,
   input  logic [9:0]                       adc_data,
   input  logic                             adc_available,
   output logic                             adc_clear_available,
   output logic [9:0]                       sample_data,
   output logic                             sample_valid,
   input  logic                             sample_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic [7:0]                       drop_count,
   output logic [7:0]                       timeout_count,
   output logic                             busy
);

   localparam int unsigned TICK_DIV = CLK_FREQ / SAMPLE_RATE;
   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned OW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [OW-1:0] TO_LAST    = OW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StWaitTick, StConvert, StCapture, StClear} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [OW-1:0] to_cnt_q, to_cnt_d;
   logic          enable_q, enable_d;
   logic          clear_q, clear_d;
   logic [9:0]    sample_q, sample_d;
   logic [7:0]    drop_q, drop_d;
   logic [7:0]    timeout_q, timeout_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic [9:0]    mem_q [FIFO_DEPTH];

   logic       tick, tick_drop, push, push_drop, timeout_inc;
   logic       full, empty, do_push, do_pop;
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   // The divider starts one cycle after run rises (once the FSM has left IDLE), so the
   // first tick lands TICK_DIV cycles after run and adc_enable follows one cycle later.
   always_comb begin
      tick       = 1'b0;
      tick_cnt_d = tick_cnt_q;
      if (!run) begin
         tick_cnt_d = '0;
      end else if (state_q != StIdle) begin
         tick       = (tick_cnt_q == TICK_LAST);
         tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      enable_d    = enable_q;
      clear_d     = 1'b0;
      to_cnt_d    = to_cnt_q;
      sample_d    = sample_q;
      push        = 1'b0;
      timeout_inc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (run) state_d = StWaitTick;
         end
         StWaitTick: begin
            if (!run) begin
               state_d = StIdle;
            end else if (tick) begin
               state_d  = StConvert;
               enable_d = 1'b1;
               to_cnt_d = '0;
            end
         end
         StConvert: begin
            to_cnt_d = to_cnt_q + OW'(1);
            if (adc_available) begin
               sample_d = adc_data;
               enable_d = 1'b0;
               state_d  = StCapture;
            end else if (to_cnt_q == TO_LAST) begin
               enable_d    = 1'b0;
               timeout_inc = 1'b1;
               clear_d     = 1'b1;
               state_d     = StClear;
            end
         end
         StCapture: begin
            push    = 1'b1;
            clear_d = 1'b1;
            state_d = StClear;
         end
         StClear: begin
            state_d = run ? StWaitTick : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Full is judged on pre-pop occupancy, so a push into a full FIFO is refused even if
   // the head leaves in the same cycle.
   assign full      = (level_q == LEVEL_FULL);
   assign empty     = (level_q == '0);
   assign do_push   = push && !full;
   assign do_pop    = sample_ready && !empty;
   assign push_drop = push && full;
   assign tick_drop = tick && (state_q inside {StConvert, StCapture, StClear});

   always_comb begin
      level_d = level_q;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   assign drop_inc  = {1'b0, tick_drop} + {1'b0, push_drop};
   assign drop_sum  = {1'b0, drop_q} + {7'b0, drop_inc};
   assign drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   assign timeout_d = (timeout_inc && timeout_q != 8'hFF) ? timeout_q + 8'd1 : timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         to_cnt_q   <= '0;
         enable_q   <= 1'b0;
         clear_q    <= 1'b0;
         sample_q   <= '0;
         drop_q     <= '0;
         timeout_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         to_cnt_q   <= to_cnt_d;
         enable_q   <= enable_d;
         clear_q    <= clear_d;
         sample_q   <= sample_d;
         drop_q     <= drop_d;
         timeout_q  <= timeout_d;
         level_q    <= level_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= sample_q;
   end

   assign adc_enable          = enable_q;
   assign adc_clear_available = clear_q;
   assign sample_valid        = !empty;
   assign sample_data         = empty ? 10'd0 : mem_q[rd_ptr_q];
   assign fifo_level          = level_q;
   assign drop_count          = drop_q;
   assign timeout_count       = timeout_q;
   assign busy                = (state_q != StIdle);

endmodule
